mode_sel_scheduler: RTL and testbench

//  Sequences all writes to the 3-bit mode-select PIO (Avalon-MM slave, data reg at address 0).

---
 rtl/mode_sel_pkg.sv | 32 +++
 rtl/mode_sel_scheduler_arbiter.sv | 40 ++++
 rtl/mode_sel_scheduler.sv | 186 ++++++++++++++++++
 tb/tb_mode_sel_scheduler.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mode_sel_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mode_sel_pkg
// Brief    : Shared types and constants for the mode-select PIO scheduler.
// Revision : 1.0 - initial release
// ============================================================================
package mode_sel_pkg;

    // Data register offset inside the PIO slave
    localparam logic [1:0] PIO_DATA_ADDR = 2'd0;

    // Default mode width; matches the PIO data width
    localparam int MODE_W_DEFAULT = 3;

    // Scheduler states
    typedef enum logic [2:0] {
        ST_INIT   = 3'd0,
        ST_IDLE   = 3'd1,
        ST_WRITE  = 3'd2,
        ST_VERIFY = 3'd3,
        ST_HOLD   = 3'd4
    } state_t;

    // Width of the dwell counter; never below one bit so HOLD_CYCLES=0 still elaborates
    function automatic int hold_cnt_width(input int hold_cycles);
        int w;
        w = $clog2(hold_cycles + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mode_sel_scheduler_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Brief    : Combinational round-robin pick: first set request at or after
//            ptr, wrapping. The pointer register lives in the parent.
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0]          req,
    input  logic [$clog2(N)-1:0]  ptr,
    input  logic                  en,
    output logic [N-1:0]          gnt,
    output logic [$clog2(N)-1:0]  idx
);

    localparam int c_idx_w = $clog2(N);

    logic               w_found;
    logic [c_idx_w-1:0] w_pos;

    // Walk the requesters starting at ptr and take the first one asserted
    always_comb begin
        gnt     = '0;
        idx     = '0;
        w_found = 1'b0;
        w_pos   = '0;
        for (int k = 0; k < N; k++) begin
            w_pos = c_idx_w'((int'(ptr) + k) % N);
            if (en && !w_found && req[w_pos]) begin
                w_found    = 1'b1;
                gnt[w_pos] = 1'b1;
                idx        = w_pos;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/mode_sel_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : mode_sel_scheduler
// Brief    : Sole Avalon-MM master of the mode-select PIO. Arbitrates mode
//            change requests round-robin, writes the mode, reads it back,
//            flags mismatches and enforces a dwell between changes.
// Revision : 1.0 - initial release
// ============================================================================
module mode_sel_scheduler
    import mode_sel_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int MODE_W       = MODE_W_DEFAULT,
    parameter int HOLD_CYCLES  = 16,
    parameter int DEFAULT_MODE = 0
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*MODE_W-1:0] req_mode,
    output logic [NUM_REQ-1:0]        grant,
    output logic                      busy,
    output logic [MODE_W-1:0]         cur_mode,
    output logic                      mismatch_err,
    output logic [1:0]                avm_address,
    output logic                      avm_chipselect,
    output logic                      avm_write_n,
    output logic [31:0]               avm_writedata,
    input  logic [31:0]               avm_readdata
);

    localparam int                  c_idx_w        = $clog2(NUM_REQ);
    localparam int                  c_hold_w       = hold_cnt_width(HOLD_CYCLES);
    localparam int                  c_bus_w        = 32;
    localparam logic [MODE_W-1:0]   c_default_mode = MODE_W'(DEFAULT_MODE);
    localparam logic [c_hold_w-1:0] c_hold_last    =
        c_hold_w'((HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0);

    state_t              r_state;
    logic [NUM_REQ-1:0]  r_grant;
    logic                r_busy;
    logic [MODE_W-1:0]   r_cur_mode;
    logic                r_mismatch_err;
    logic [1:0]          r_address;
    logic                r_chipselect;
    logic                r_write_n;
    logic [c_bus_w-1:0]  r_writedata;
    logic [c_idx_w-1:0]  r_rr_ptr;
    logic [MODE_W-1:0]   r_mode_latch;
    logic [c_hold_w-1:0] r_hold_cnt;
    logic                r_init_pass;

    logic                w_arb_en;
    logic [NUM_REQ-1:0]  w_arb_gnt;
    logic [c_idx_w-1:0]  w_arb_idx;
    logic                w_arb_valid;
    logic [MODE_W-1:0]   w_sel_mode;
    logic [c_idx_w-1:0]  w_rr_next;
    logic [MODE_W-1:0]   w_readback;

    // Arbitrate only in IDLE and not while a grant is still pulsing, so a
    // requester that has not yet dropped req cannot be served twice.
    assign w_arb_en    = (r_state == ST_IDLE) && (r_grant == '0);
    assign w_arb_valid = |w_arb_gnt;
    assign w_sel_mode  = req_mode[w_arb_idx*MODE_W +: MODE_W];
    assign w_rr_next   = (w_arb_idx == c_idx_w'(NUM_REQ - 1)) ? '0 : w_arb_idx + 1'b1;
    assign w_readback  = avm_readdata[MODE_W-1:0];

    generate
        if (MODE_W < c_bus_w) begin : g_rd_hi
            logic w_unused_readdata_hi;
            assign w_unused_readdata_hi = |avm_readdata[c_bus_w-1:MODE_W];
        end
    endgenerate

    rr_arbiter #(
        .N (NUM_REQ)
    ) u_arb (
        .req (req),
        .ptr (r_rr_ptr),
        .en  (w_arb_en),
        .gnt (w_arb_gnt),
        .idx (w_arb_idx)
    );

    // Scheduler FSM; bus outputs are loaded with the values of the state being
    // entered so that each state's bus cycle lines up with the state itself.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state        <= ST_INIT;
            r_grant        <= '0;
            r_busy         <= 1'b1;
            r_cur_mode     <= c_default_mode;
            r_mismatch_err <= 1'b0;
            r_address      <= PIO_DATA_ADDR;
            r_chipselect   <= 1'b0;
            r_write_n      <= 1'b1;
            r_writedata    <= '0;
            r_rr_ptr       <= '0;
            r_mode_latch   <= c_default_mode;
            r_hold_cnt     <= '0;
            r_init_pass    <= 1'b1;
        end else begin
            r_grant   <= '0;
            r_address <= PIO_DATA_ADDR;
            case (r_state)
                ST_INIT: begin
                    // The reset cycle leaves the bus idle; launch the default
                    // write on the first clock after release, then read it back.
                    if (!r_chipselect) begin
                        r_chipselect <= 1'b1;
                        r_write_n    <= 1'b0;
                        r_writedata  <= c_bus_w'(c_default_mode);
                        r_mode_latch <= c_default_mode;
                        r_init_pass  <= 1'b1;
                    end else begin
                        r_state   <= ST_VERIFY;
                        r_write_n <= 1'b1;
                    end
                end
                ST_IDLE: begin
                    if (w_arb_valid) begin
                        r_grant      <= w_arb_gnt;
                        r_rr_ptr     <= w_rr_next;
                        r_mode_latch <= w_sel_mode;
                        // A request for the mode already in force is acknowledged
                        // without touching the bus.
                        if (w_sel_mode != r_cur_mode) begin
                            r_state      <= ST_WRITE;
                            r_busy       <= 1'b1;
                            r_chipselect <= 1'b1;
                            r_write_n    <= 1'b0;
                            r_writedata  <= c_bus_w'(w_sel_mode);
                        end
                    end
                end
                ST_WRITE: begin
                    r_state   <= ST_VERIFY;
                    r_write_n <= 1'b1;
                end
                ST_VERIFY: begin
                    r_chipselect <= 1'b0;
                    r_write_n    <= 1'b1;
                    r_cur_mode   <= r_mode_latch;
                    r_init_pass  <= 1'b0;
                    if (w_readback != r_mode_latch) begin
                        r_mismatch_err <= 1'b1;
                    end
                    // The power-up write carries no dwell
                    if (r_init_pass || (HOLD_CYCLES == 0)) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_state    <= ST_HOLD;
                        r_hold_cnt <= '0;
                    end
                end
                ST_HOLD: begin
                    if (r_hold_cnt == c_hold_last) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_hold_cnt <= r_hold_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state      <= ST_IDLE;
                    r_busy       <= 1'b0;
                    r_chipselect <= 1'b0;
                    r_write_n    <= 1'b1;
                end
            endcase
        end
    end

    assign grant          = r_grant;
    assign busy           = r_busy;
    assign cur_mode       = r_cur_mode;
    assign mismatch_err   = r_mismatch_err;
    assign avm_address    = r_address;
    assign avm_chipselect = r_chipselect;
    assign avm_write_n    = r_write_n;
    assign avm_writedata  = r_writedata;

endmodule
`default_nettype wire

// File: tb/tb_mode_sel_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_mode_sel_scheduler
// Brief    : Directed self-checking bench for mode_sel_scheduler with a
//            simple PIO register model behind the Avalon port.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mode_sel_scheduler;

    localparam int NR = 4;
    localparam int MW = 3;
    localparam int HC = 16;
    localparam int DM = 0;

    logic              clk = 1'b0;
    logic              reset_n;
    logic [NR-1:0]     req;
    logic [NR*MW-1:0]  req_mode;
    logic [NR-1:0]     grant;
    logic              busy;
    logic [MW-1:0]     cur_mode;
    logic              mismatch_err;
    logic [1:0]        avm_address;
    logic              avm_chipselect;
    logic              avm_write_n;
    logic [31:0]       avm_writedata;
    logic [31:0]       avm_readdata;

    logic [31:0]       pio_reg   = 32'h7;
    logic              force_bad = 1'b0;
    int                wr_count  = 0;

    int n_err = 0;
    int n_chk = 0;

    always #5 clk = ~clk;

    mode_sel_scheduler #(
        .NUM_REQ      (NR),
        .MODE_W       (MW),
        .HOLD_CYCLES  (HC),
        .DEFAULT_MODE (DM)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .req            (req),
        .req_mode       (req_mode),
        .grant          (grant),
        .busy           (busy),
        .cur_mode       (cur_mode),
        .mismatch_err   (mismatch_err),
        .avm_address    (avm_address),
        .avm_chipselect (avm_chipselect),
        .avm_write_n    (avm_write_n),
        .avm_writedata  (avm_writedata),
        .avm_readdata   (avm_readdata)
    );

    // PIO data register model and write counter
    always @(posedge clk) begin
        if (avm_chipselect && !avm_write_n) begin
            pio_reg  <= avm_writedata;
            wr_count <= wr_count + 1;
        end
    end

    assign avm_readdata = force_bad ? 32'd0 : pio_reg;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int oh_idx(input logic [NR-1:0] v);
        for (int i = 0; i < NR; i++) begin
            if (v[i]) return i;
        end
        return -1;
    endfunction

    task automatic set_mode(input int i, input logic [MW-1:0] m);
        req_mode[i*MW +: MW] = m;
    endtask

    task automatic wait_grant(input int budget, output int idx, output int cycles);
        idx    = -1;
        cycles = 0;
        while (cycles < budget) begin
            tick();
            cycles++;
            if (grant != '0) begin
                idx = oh_idx(grant);
                break;
            end
        end
    endtask

    task automatic wait_idle(input int budget, output int cycles);
        cycles = 0;
        while (busy && (cycles < budget)) begin
            tick();
            cycles++;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int idx;
        int cyc;
        int w0;
        int exp_order [5];
        exp_order = '{0, 1, 2, 3, 0};

        reset_n  = 1'b0;
        req      = '0;
        req_mode = '0;
        repeat (3) tick();

        // Reset values
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_busy", 32'(busy), 32'd1);
        check("rst_cur_mode", 32'(cur_mode), 32'(DM));
        check("rst_err", 32'(mismatch_err), 32'd0);
        check("rst_cs", 32'(avm_chipselect), 32'd0);
        check("rst_write_n", 32'(avm_write_n), 32'd1);
        check("rst_addr", 32'(avm_address), 32'd0);
        check("rst_wdata", avm_writedata, 32'd0);

        // Power-up write of DEFAULT_MODE, readback, then idle
        reset_n = 1'b1;
        tick();
        check("init_cs", 32'(avm_chipselect), 32'd1);
        check("init_write_n", 32'(avm_write_n), 32'd0);
        check("init_wdata", avm_writedata, 32'(DM));
        check("init_addr", 32'(avm_address), 32'd0);
        check("init_grant", 32'(grant), 32'd0);
        tick();
        check("init_rd_cs", 32'(avm_chipselect), 32'd1);
        check("init_rd_write_n", 32'(avm_write_n), 32'd1);
        tick();
        check("init_busy", 32'(busy), 32'd0);
        check("init_cs_off", 32'(avm_chipselect), 32'd0);
        check("init_cur_mode", 32'(cur_mode), 32'(DM));
        check("init_pio", pio_reg, 32'(DM));
        check("init_err", 32'(mismatch_err), 32'd0);

        // Single request: requester 2, mode 5
        w0 = wr_count;
        set_mode(2, 3'd5);
        req = 4'b0100;
        tick();
        check("r2_grant", 32'(grant), 32'h4);
        check("r2_wr_cs", 32'(avm_chipselect), 32'd1);
        check("r2_wr_write_n", 32'(avm_write_n), 32'd0);
        check("r2_wr_wdata", avm_writedata, 32'd5);
        check("r2_busy", 32'(busy), 32'd1);
        req = '0;
        tick();
        check("r2_vf_grant", 32'(grant), 32'd0);
        check("r2_vf_cs", 32'(avm_chipselect), 32'd1);
        check("r2_vf_write_n", 32'(avm_write_n), 32'd1);
        tick();
        check("r2_hold_cs", 32'(avm_chipselect), 32'd0);
        check("r2_cur_mode", 32'(cur_mode), 32'd5);
        check("r2_hold_busy", 32'(busy), 32'd1);
        wait_idle(100, cyc);
        check("r2_hold_len", 32'(cyc), 32'(HC));
        check("r2_writes", 32'(wr_count - w0), 32'd1);
        check("r2_err", 32'(mismatch_err), 32'd0);

        // Request for the mode already in force: grant only, no bus cycle
        w0 = wr_count;
        set_mode(3, 3'd5);
        req = 4'b1000;
        tick();
        check("same_grant", 32'(grant), 32'h8);
        check("same_cs", 32'(avm_chipselect), 32'd0);
        check("same_busy", 32'(busy), 32'd0);
        req = '0;
        tick();
        check("same_grant_end", 32'(grant), 32'd0);
        check("same_busy2", 32'(busy), 32'd0);
        check("same_writes", 32'(wr_count - w0), 32'd0);

        // All four requesting with distinct modes, held high
        w0 = wr_count;
        set_mode(0, 3'd1);
        set_mode(1, 3'd2);
        set_mode(2, 3'd3);
        set_mode(3, 3'd4);
        req = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            wait_grant(200, idx, cyc);
            check("rr_order", 32'(idx), 32'(exp_order[g]));
            check("rr_write_n", 32'(avm_write_n), 32'd0);
            if (g > 0) check("rr_gap", 32'(cyc), 32'(HC + 3));
            if (g == 4) req = '0;
        end
        wait_idle(100, cyc);
        check("rr_writes", 32'(wr_count - w0), 32'd5);
        check("rr_cur_mode", 32'(cur_mode), 32'd1);

        // Bad readback during the write of mode 6
        force_bad = 1'b1;
        set_mode(1, 3'd6);
        req = 4'b0010;
        wait_grant(10, idx, cyc);
        check("mm_grant_idx", 32'(idx), 32'd1);
        req = '0;
        wait_idle(100, cyc);
        force_bad = 1'b0;
        check("mm_err", 32'(mismatch_err), 32'd1);
        check("mm_cur_mode", 32'(cur_mode), 32'd6);

        // A later good write leaves the sticky flag set
        set_mode(2, 3'd2);
        req = 4'b0100;
        wait_grant(10, idx, cyc);
        check("mm2_grant_idx", 32'(idx), 32'd2);
        req = '0;
        wait_idle(100, cyc);
        check("mm2_err_sticky", 32'(mismatch_err), 32'd1);
        check("mm2_cur_mode", 32'(cur_mode), 32'd2);
        check("mm2_pio", pio_reg, 32'd2);

        // Reset asserted during HOLD
        set_mode(3, 3'd7);
        req = 4'b1000;
        wait_grant(10, idx, cyc);
        check("hr_grant_idx", 32'(idx), 32'd3);
        req = '0;
        repeat (5) tick();
        check("hr_in_hold", 32'(busy), 32'd1);
        reset_n = 1'b0;
        tick();
        check("hr_grant", 32'(grant), 32'd0);
        check("hr_busy", 32'(busy), 32'd1);
        check("hr_cs", 32'(avm_chipselect), 32'd0);
        check("hr_write_n", 32'(avm_write_n), 32'd1);
        check("hr_err_clr", 32'(mismatch_err), 32'd0);
        check("hr_cur_mode", 32'(cur_mode), 32'(DM));
        reset_n = 1'b1;
        tick();
        check("hr_init_cs", 32'(avm_chipselect), 32'd1);
        check("hr_init_write_n", 32'(avm_write_n), 32'd0);
        check("hr_init_wdata", avm_writedata, 32'(DM));
        tick();
        tick();
        check("hr_busy_end", 32'(busy), 32'd0);
        check("hr_cur_mode_end", 32'(cur_mode), 32'(DM));
        check("hr_pio", pio_reg, 32'(DM));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
